accel_cpu_ocimem_arbiter: RTL and testbench

Sequencer and arbiter for the Nios II debug on-chip memory (OCI RAM, single-port, 2^ADDR_W × 32, 1-cycle read latency). Shares the RAM between the JTAG debug path (take_action/jdo command pulses from the debug slave sysclk side) and the CPU's Avalon debug_mem slave. Manages the JTAG auto-increment address, MonDReg capture and monitor_ready/monitor_error status.

---
 rtl/accel_cpu_ocimem_arb_pkg.sv | 39 +++
 rtl/accel_cpu_ocimem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_accel_cpu_ocimem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_cpu_ocimem_arb_pkg.sv
// Shared types and constants for the OCI RAM sequencer/arbiter.
// Holds the FSM state encoding, JTAG command kinds, grant owner and jdo field positions.
// Pure declarations; no timing or flow control lives here.
package accel_cpu_ocimem_arb_pkg;

  // jdo word layout: 38 bits, address field at [lsb +: ADDR_W], data at [34:3]
  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 10;
  localparam int JDO_DATA_LSB = 3;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_JTAG_WR      = 3'd1,
    ST_JTAG_RD      = 3'd2,
    ST_JTAG_RD_DATA = 3'd3,
    ST_AV_WR        = 3'd4,
    ST_AV_RD        = 3'd5,
    ST_AV_RD_DATA   = 3'd6
  } state_e;

  // Kind of JTAG command held in the one-deep pending register
  typedef enum logic [1:0] {
    JCMD_LOAD_ADDR = 2'd0,
    JCMD_WRITE     = 2'd1,
    JCMD_READ      = 2'd2
  } jcmd_e;

  // Owner of the most recent RAM grant, used for alternating priority
  typedef enum logic {
    GNT_JTAG = 1'b0,
    GNT_AV   = 1'b1
  } grant_e;

  // True while a JTAG command occupies the RAM port
  function automatic logic is_jtag_state(input state_e s);
    return (s == ST_JTAG_WR) || (s == ST_JTAG_RD) || (s == ST_JTAG_RD_DATA);
  endfunction

endpackage

// File: rtl/accel_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG debug commands and the Avalon debug_mem slave.
// JTAG write done 3 cycles after its pulse, JTAG read 4; Avalon write acks at t+1, read at t+2 from IDLE.
// Avalon is stalled by av_waitrequest; JTAG has no backpressure, a pulse while busy is dropped and flagged.
module accel_cpu_ocimem_arbiter
  import accel_cpu_ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // JTAG debug side
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error,
  // Avalon debug_mem slave
  input  logic [ADDR_W-1:0]     av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W/8-1:0]   av_byteenable,
  input  logic                  debugaccess,
  output logic [DATA_W-1:0]     av_readdata,
  output logic                  av_waitrequest,
  // OCI RAM port
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [DATA_W/8-1:0]   ram_byteen,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  // FSM and sequencing state
  state_e              r_state;
  grant_e              r_last_grant;

  // One-deep JTAG command holding register
  logic                r_pend_vld;
  jcmd_e               r_pend_cmd;
  logic [ADDR_W-1:0]   r_pend_addr;
  logic [DATA_W-1:0]   r_pend_dat;

  // JTAG-visible status
  logic [ADDR_W-1:0]   r_jtag_addr;
  logic [DATA_W-1:0]   r_mondreg;
  logic                r_monitor_ready;
  logic                r_monitor_error;

  // Registered RAM/Avalon drive, set on entry to the state that uses it
  logic                r_av_waitrequest;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_wren;
  logic [DATA_W/8-1:0] r_ram_byteen;
  logic [DATA_W-1:0]   r_ram_wdata;

  logic                w_pulse;
  jcmd_e               w_pulse_cmd;
  logic                w_jtag_busy;
  logic                w_jtag_req;
  logic                w_av_req;
  logic                w_grant_av;
  logic                w_grant_jtag;
  logic                w_unused_jdo;

  assign w_pulse     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // Address load wins if several pulses coincide, then write, then read
  assign w_pulse_cmd = take_action_ocimem_a ? JCMD_LOAD_ADDR :
                       (take_action_ocimem_b ? JCMD_WRITE : JCMD_READ);

  // A command is outstanding from capture until its RAM cycle finishes
  assign w_jtag_busy = r_pend_vld | is_jtag_state(r_state);

  // Address loads never touch the RAM, so only write/read compete for it
  assign w_jtag_req  = r_pend_vld && (r_pend_cmd != JCMD_LOAD_ADDR);
  assign w_av_req    = av_read | av_write;

  // Alternating priority on a tie: whoever was not served last goes first
  assign w_grant_av   = w_av_req && (!w_jtag_req || (r_last_grant == GNT_JTAG));
  assign w_grant_jtag = w_jtag_req && !w_grant_av;

  // jdo carries bits outside the address/data fields that this block ignores
  assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_DATA_LSB+DATA_W], jdo[JDO_DATA_LSB-1:0]};

  // Sequencer: pulse capture, arbitration, RAM port drive and JTAG status
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_last_grant     <= GNT_JTAG;
      r_pend_vld       <= 1'b0;
      r_pend_cmd       <= JCMD_READ;
      r_pend_addr      <= '0;
      r_pend_dat       <= '0;
      r_jtag_addr      <= '0;
      r_mondreg        <= '0;
      r_monitor_ready  <= 1'b1;
      r_monitor_error  <= 1'b0;
      r_av_waitrequest <= 1'b1;
      r_ram_addr       <= '0;
      r_ram_wren       <= 1'b0;
      r_ram_byteen     <= '0;
      r_ram_wdata      <= '0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them
      r_ram_wren       <= 1'b0;
      r_av_waitrequest <= 1'b1;

      // JTAG pulse capture; a pulse while busy is lost and flagged sticky
      if (w_pulse) begin
        if (w_jtag_busy) begin
          r_monitor_error <= 1'b1;
        end else begin
          r_pend_vld      <= 1'b1;
          r_pend_cmd      <= w_pulse_cmd;
          r_pend_addr     <= jdo[JDO_ADDR_LSB +: ADDR_W];
          r_pend_dat      <= jdo[JDO_DATA_LSB +: DATA_W];
          r_monitor_ready <= 1'b0;
          if (take_action_ocimem_a) begin
            r_monitor_error <= 1'b0;
          end
        end
      end

      case (r_state)
        ST_IDLE: begin
          // Address load retires here without needing the RAM
          if (r_pend_vld && (r_pend_cmd == JCMD_LOAD_ADDR)) begin
            r_jtag_addr     <= r_pend_addr;
            r_pend_vld      <= 1'b0;
            r_monitor_ready <= 1'b1;
          end
          if (w_grant_av) begin
            r_last_grant <= GNT_AV;
            r_ram_addr   <= av_address;
            if (av_write) begin
              // Write commits in the next cycle, only with debug access
              r_state          <= ST_AV_WR;
              r_ram_wren       <= debugaccess;
              r_ram_byteen     <= av_byteenable;
              r_ram_wdata      <= av_writedata;
              r_av_waitrequest <= 1'b0;
            end else begin
              r_state <= ST_AV_RD;
            end
          end else if (w_grant_jtag) begin
            r_last_grant <= GNT_JTAG;
            r_pend_vld   <= 1'b0;
            r_ram_addr   <= r_jtag_addr;
            if (r_pend_cmd == JCMD_WRITE) begin
              r_state      <= ST_JTAG_WR;
              r_ram_wren   <= 1'b1;
              r_ram_byteen <= '1;
              r_ram_wdata  <= r_pend_dat;
            end else begin
              r_state <= ST_JTAG_RD;
            end
          end
        end

        ST_JTAG_WR: begin
          r_jtag_addr     <= r_jtag_addr + ADDR_W'(1);
          r_monitor_ready <= 1'b1;
          r_state         <= ST_IDLE;
        end

        ST_JTAG_RD: begin
          r_state <= ST_JTAG_RD_DATA;
        end

        ST_JTAG_RD_DATA: begin
          r_mondreg       <= ram_rdata;
          r_jtag_addr     <= r_jtag_addr + ADDR_W'(1);
          r_monitor_ready <= 1'b1;
          r_state         <= ST_IDLE;
        end

        ST_AV_WR: begin
          r_state <= ST_IDLE;
        end

        ST_AV_RD: begin
          // RAM data lands next cycle, so release the master then
          r_av_waitrequest <= 1'b0;
          r_state          <= ST_AV_RD_DATA;
        end

        ST_AV_RD_DATA: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MonDReg        = r_mondreg;
  assign monitor_ready  = r_monitor_ready;
  assign monitor_error  = r_monitor_error;
  // RAM output is already registered inside the RAM; qualified by av_waitrequest
  assign av_readdata    = ram_rdata;
  assign av_waitrequest = r_av_waitrequest;
  assign ram_addr       = r_ram_addr;
  assign ram_wren       = r_ram_wren;
  assign ram_byteen     = r_ram_byteen;
  assign ram_wdata      = r_ram_wdata;

endmodule

// File: tb/tb_accel_cpu_ocimem_arbiter.sv
// Scoreboard bench for accel_cpu_ocimem_arbiter with a behavioural 1-cycle-latency RAM.
// Stimulus pushes expected Avalon acks, JTAG completions and RAM writes; monitors pop on DUT events.
// Expected cycles are relative to the cycle in which the request is driven.
module tb_accel_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        debugaccess;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  accel_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable), .debugaccess(debugaccess),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural OCI RAM: byte-enabled write, registered read
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
  always @(posedge clk) begin
    if (ram_wren === 1'b1)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  typedef struct { logic is_rd; logic [31:0] rd; int cyc; } av_exp_t;
  typedef struct { int cyc; logic [31:0] mon; } jt_exp_t;
  typedef struct { logic [7:0] addr; logic [3:0] be; logic [31:0] wd; } wr_exp_t;
  av_exp_t av_q[$];
  jt_exp_t jt_q[$];
  wr_exp_t wr_q[$];

  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic prev_rdy = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Avalon monitor: every released waitrequest is one completed transfer
  always @(negedge clk) begin : av_mon
    av_exp_t e;
    if (mon_en && av_waitrequest === 1'b0) begin
      if (av_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL av_unexpected_ack: got ack at cycle %0d, expected none", cyc);
      end else begin
        e = av_q.pop_front();
        chk("av_ack_cycle", cyc, e.cyc);
        chk("av_kind_is_read", {31'b0, av_read}, {31'b0, e.is_rd});
        if (e.is_rd) chk("av_readdata", av_readdata, e.rd);
      end
    end
  end

  // JTAG monitor: a rising monitor_ready marks command completion
  always @(negedge clk) begin : jt_mon
    jt_exp_t e;
    if (mon_en) begin
      if (prev_rdy === 1'b0 && monitor_ready === 1'b1) begin
        if (jt_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL jtag_unexpected_done: got completion at cycle %0d, expected none", cyc);
        end else begin
          e = jt_q.pop_front();
          chk("jtag_done_cycle", cyc, e.cyc);
          chk("MonDReg", MonDReg, e.mon);
        end
      end
      prev_rdy <= monitor_ready;
    end
  end

  // RAM write monitor
  always @(negedge clk) begin : wr_mon
    wr_exp_t e;
    if (mon_en && ram_wren === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL ram_unexpected_write: got addr %h data %h, expected no write", ram_addr, ram_wdata);
      end else begin
        e = wr_q.pop_front();
        chk("ram_wr_addr", {24'b0, ram_addr}, {24'b0, e.addr});
        chk("ram_wr_byteen", {28'b0, ram_byteen}, {28'b0, e.be});
        chk("ram_wr_data", ram_wdata, e.wd);
      end
    end
  end

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    logic [37:0] v;
    v = '1;
    v[17:10] = a;
    return v;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[37:35] = 3'b110;
    v[2:0]   = 3'b101;
    v[34:3]  = d;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_waitrequest"}, {31'b0, av_waitrequest}, 32'd1);
    chk({tag, "_ram_wren"}, {31'b0, ram_wren}, 32'd0);
    chk({tag, "_monitor_ready"}, {31'b0, monitor_ready}, 32'd1);
    chk({tag, "_monitor_error"}, {31'b0, monitor_error}, 32'd0);
    chk({tag, "_MonDReg"}, MonDReg, 32'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    av_read = 0; av_write = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One-cycle JTAG pulse driven in the current cycle
  task automatic jtag_pulse(input int kind, input logic [37:0] v);
    jdo = v;
    case (kind)
      0:       take_action_ocimem_a = 1'b1;
      1:       take_action_ocimem_b = 1'b1;
      default: take_no_action_ocimem_a = 1'b1;
    endcase
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_cmd(input int kind, input logic [37:0] v, input int lat, input logic [31:0] mon);
    jt_exp_t e;
    e.cyc = cyc + lat; e.mon = mon;
    jt_q.push_back(e);
    jtag_pulse(kind, v);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_exp_t e;
    e.addr = a; e.be = be; e.wd = d;
    wr_q.push_back(e);
  endtask

  // Avalon transfer; request held until waitrequest drops (bounded wait)
  task automatic av_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic dbg, input int lat,
                         input logic [31:0] exp_rd, input logic keep);
    av_exp_t e;
    int k;
    av_address = addr; av_writedata = wd; av_byteenable = be; debugaccess = dbg;
    av_write = wr; av_read = ~wr;
    e.is_rd = ~wr; e.rd = exp_rd; e.cyc = cyc + lat;
    av_q.push_back(e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (av_waitrequest !== 1'b0 && k < 20);
    if (av_waitrequest !== 1'b0) begin
      n_vec++; n_err++;
      $display("FAIL av_timeout: got no ack within 20 cycles, expected ack at cycle %0d", e.cyc);
    end
    @(posedge clk); #1;
    if (!keep) begin av_read = 1'b0; av_write = 1'b0; end
  endtask

  initial begin
    jt_exp_t je;
    jdo = '0; av_address = '0; av_writedata = '0; av_byteenable = '0; debugaccess = 1'b0;
    reset_dut();
    mon_en = 1'b1;

    // Address load, write, then read-after-increment
    jtag_cmd(0, jdo_addr(8'h10), 2, 32'h0);
    push_wr(8'h10, 4'hF, 32'hDEADBEEF);
    jtag_cmd(1, jdo_data(32'hDEADBEEF), 3, 32'h0);
    jtag_cmd(2, '1, 4, 32'hC0DE0011);
    av_xfer(1'b0, 8'h10, '0, 4'h0, 1'b0, 2, 32'hDEADBEEF, 1'b0);

    // Auto-increment wraps 0xFF -> 0x00
    jtag_cmd(0, jdo_addr(8'hFF), 2, 32'hC0DE0011);
    jtag_cmd(2, '1, 4, 32'hC0DE00FF);
    jtag_cmd(2, '1, 4, 32'hC0DE0000);

    // Tie from reset: Avalon first, then JTAG wins the next tie
    reset_dut();
    push_wr(8'h00, 4'hF, 32'h11112222);
    je.cyc = cyc + 6; je.mon = 32'h0;
    jt_q.push_back(je);
    jtag_pulse(1, jdo_data(32'h11112222));
    av_xfer(1'b0, 8'h20, '0, 4'h0, 1'b0, 2, 32'hC0DE0020, 1'b1);
    av_xfer(1'b0, 8'h21, '0, 4'h0, 1'b0, 4, 32'hC0DE0021, 1'b0);
    av_xfer(1'b0, 8'h00, '0, 4'h0, 1'b0, 2, 32'h11112222, 1'b0);

    // Writes without/with debugaccess, partial byte enables
    av_xfer(1'b1, 8'h30, 32'h5A5A5A5A, 4'b0011, 1'b0, 1, '0, 1'b0);
    av_xfer(1'b0, 8'h30, '0, 4'h0, 1'b0, 2, 32'hC0DE0030, 1'b0);
    push_wr(8'h30, 4'b0011, 32'h5A5A5A5A);
    av_xfer(1'b1, 8'h30, 32'h5A5A5A5A, 4'b0011, 1'b1, 1, '0, 1'b0);
    av_xfer(1'b0, 8'h30, '0, 4'h0, 1'b0, 2, 32'hC0DE5A5A, 1'b0);

    // Overrun: second pulse one cycle later is dropped and flagged
    push_wr(8'h01, 4'hF, 32'h0BADF00D);
    je.cyc = cyc + 3; je.mon = 32'h0;
    jt_q.push_back(je);
    jtag_pulse(1, jdo_data(32'h0BADF00D));
    jtag_pulse(2, '1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("monitor_error_set", {31'b0, monitor_error}, 32'd1);
    chk("MonDReg_after_drop", MonDReg, 32'h0);
    @(posedge clk); #1;
    jtag_cmd(0, jdo_addr(8'h40), 2, 32'h0);
    @(negedge clk);
    chk("monitor_error_cleared", {31'b0, monitor_error}, 32'd0);
    @(posedge clk); #1;
    jtag_cmd(2, '1, 4, 32'hC0DE0040);
    av_xfer(1'b0, 8'h01, '0, 4'h0, 1'b0, 2, 32'h0BADF00D, 1'b0);

    // Reset while in AV_RD: aborts, next cycle shows reset values
    av_address = 8'h50; av_read = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; av_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    av_xfer(1'b0, 8'h50, '0, 4'h0, 1'b0, 2, 32'hC0DE0050, 1'b0);
    jtag_cmd(2, '1, 4, 32'h11112222);

    repeat (5) @(posedge clk);
    #1;
    chk("av_queue_drained", av_q.size(), 32'd0);
    chk("jtag_queue_drained", jt_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
